// File: rtl/sparc_ifu_thrreq4_if.sv
// Request/grant handshake between the per-thread request tracker and the
// LRU grant arbiter of the four-thread IFU fetch scheduler.
interface sparc_ifu_thrreq4_if;
    logic [3:0] req_vec;
    logic [3:0] spec_vec;
    logic       use_spec;
    logic [3:0] grant_vec;
    logic [3:0] recent_vec;
    logic       load_recent;

    // Tracker side: publishes requests, consumes the one-hot grant.
    modport master (
        output req_vec,
        output spec_vec,
        output use_spec,
        output recent_vec,
        output load_recent,
        input  grant_vec
    );

    // Arbiter side.
    modport slave (
        input  req_vec,
        input  spec_vec,
        input  use_spec,
        input  recent_vec,
        input  load_recent,
        output grant_vec
    );
endinterface

// File: rtl/sparc_ifu_thrreq4.sv
// Per-thread request tracker for the four-thread IFU fetch scheduler: raises
// ready/speculative requests, accepts arbiter grants and holds granted threads busy.
module sparc_ifu_thrreq4 #(
    parameter int HOLD_CYC = 2
) (
    input  logic                   clk,
    input  logic                   arst_l,
    input  logic [3:0]             rdy_set,
    input  logic [3:0]             spec_set,
    input  logic [3:0]             spec_cfm,
    input  logic [3:0]             spec_kill,
    input  logic                   stall,
    sparc_ifu_thrreq4_if.master    arb,
    output logic [3:0]             sel_thr,
    output logic                   sel_vld,
    output logic                   sel_spec,
    output logic                   gnt_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPEC = 2'd1,
        ST_RDY  = 2'd2,
        ST_BUSY = 2'd3
    } thr_state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

    logic [3:0] req_vec_w;
    logic [3:0] spec_vec_w;
    logic       use_spec_w;
    logic [3:0] grant;
    logic       grant_onehot;
    logic       grant_legal;
    logic       grant_bad;
    logic       acc;

    assign grant        = arb.grant_vec;
    assign use_spec_w   = ~(|req_vec_w) & (|spec_vec_w);
    assign grant_onehot = (grant != 4'd0) && ((grant & (grant - 4'd1)) == 4'd0);
    // The granted thread must belong to the pool the arbiter was told to use.
    assign grant_legal  = grant_onehot &&
                          (|(grant & (use_spec_w ? spec_vec_w : req_vec_w)));
    assign grant_bad    = (grant != 4'd0) && !grant_legal;
    assign acc          = grant_legal & ~stall;

    assign arb.req_vec     = req_vec_w;
    assign arb.spec_vec    = spec_vec_w;
    assign arb.use_spec    = use_spec_w;
    assign arb.load_recent = acc;
    assign arb.recent_vec  = grant & {4{acc}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_thr
            thr_state_t state_reg, state_next;
            logic [3:0] cnt_reg, cnt_next;
            logic       pend_reg, pend_next;
            logic       thr_acc;
            logic       thr_req, thr_spec;

            assign thr_acc = acc & grant[gi];

            always_ff @(posedge clk or negedge arst_l) begin
                if (!arst_l) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 4'd0;
                    pend_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    pend_reg  <= pend_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                pend_next  = pend_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (rdy_set[gi])       state_next = ST_RDY;
                        else if (spec_set[gi]) state_next = ST_SPEC;
                    end
                    // A grant wins over a same-cycle kill; the fetched thread is
                    // killed further down the pipe.
                    ST_SPEC: begin
                        if (thr_acc) begin
                            state_next = ST_BUSY;
                            cnt_next   = HOLD_LOAD;
                        end else if (spec_kill[gi]) begin
                            state_next = ST_IDLE;
                        end else if (rdy_set[gi] | spec_cfm[gi]) begin
                            state_next = ST_RDY;
                        end
                    end
                    ST_RDY: begin
                        if (thr_acc) begin
                            state_next = ST_BUSY;
                            cnt_next   = HOLD_LOAD;
                        end
                    end
                    ST_BUSY: begin
                        if (cnt_reg == 4'd0) begin
                            state_next = (pend_reg | rdy_set[gi]) ? ST_RDY : ST_IDLE;
                            pend_next  = 1'b0;
                        end else begin
                            cnt_next = cnt_reg - 4'd1;
                            if (rdy_set[gi]) pend_next = 1'b1;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            always_comb begin
                thr_req  = (state_reg == ST_RDY);
                thr_spec = (state_reg == ST_SPEC);
            end

            assign req_vec_w[gi]  = thr_req;
            assign spec_vec_w[gi] = thr_spec;
        end
    endgenerate

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            sel_thr  <= 4'd0;
            sel_vld  <= 1'b0;
            sel_spec <= 1'b0;
            gnt_err  <= 1'b0;
        end else begin
            sel_thr  <= grant & {4{acc}};
            sel_vld  <= acc;
            sel_spec <= acc & use_spec_w;
            // Protocol errors are flagged even when the grant is stalled.
            if (grant_bad) gnt_err <= 1'b1;
        end
    end

endmodule
